// File: rtl/uart_burst_pkg.sv
// Shared types and helpers for the burst UART transmitter (and a future receiver).
package uart_burst_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } tx_state_t;

  // A speed of zero would give a zero-length bit period, so it is promoted to 1.
  function automatic logic [7:0] eff_speed(input logic [7:0] speed);
    return (speed == 8'd0) ? 8'd1 : speed;
  endfunction

endpackage

// File: rtl/uart_burst_tx_baud_tick_gen.sv
// Bit-period timer: latches a period on load, then pulses tick on every
// period-th enabled cycle. Shared with the planned UART receiver.
module baud_tick_gen #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] count_q;

  assign tick = enable && (count_q == period_q - WIDTH'(1));

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      count_q  <= '0;
    end else if (load) begin
      period_q <= period;
      count_q  <= '0;
    end else if (enable) begin
      count_q <= tick ? '0 : count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_burst_tx.sv
// Burst UART transmitter: sends the snapshotted byte num_of_bytes times as 8N1
// frames. Define PARITY_EN to insert an even-parity bit between data and stop.
module uart_burst_tx
  import uart_burst_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int CYCLES_PER_UNIT = 651,
  parameter int IDLE_GAP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num,
  input  logic [7:0] speed,
  input  logic [7:0] num_of_bytes,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_count
);

  localparam int TW = DATA_BITS + $clog2(CYCLES_PER_UNIT);

  if (CLK_FREQ <= 0 || CYCLES_PER_UNIT <= 0 || IDLE_GAP_BITS < 0) begin : g_bad_params
    $error("uart_burst_tx: CLK_FREQ and CYCLES_PER_UNIT must be positive, IDLE_GAP_BITS non-negative");
  end

  tx_state_t   state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  data_q;
  logic [7:0]  nbytes_q;
  logic [7:0]  byte_count_q;
  logic        tx_q, tx_d;
  logic        zero_done_q;
  logic [TW-1:0] period_calc;
  logic        accept, load, tick, last_frame, stop_done;

  assign accept      = (state_q == IDLE) && start;
  assign load        = accept && (num_of_bytes != 8'd0);
  assign last_frame  = (byte_count_q + 8'd1) == nbytes_q;
  assign stop_done   = (state_q == STOP) && tick && last_frame;
  assign period_calc = TW'(eff_speed(speed)) * TW'(CYCLES_PER_UNIT);

  baud_tick_gen #(.WIDTH(TW)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .enable (state_q != IDLE),
    .period (period_calc),
    .tick   (tick)
  );

  function automatic logic tx_level(input tx_state_t st, input logic [2:0] idx,
                                    input logic [7:0] data);
    case (st)
      START:   return 1'b0;
      DATA:    return data[idx];
`ifdef PARITY_EN
      PARITY:  return ^data;
`endif
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE:  if (load) state_d = START;
      START: if (tick) begin
        state_d = DATA;
        idx_d   = 3'd0;
      end
      DATA:  if (tick) begin
        if (idx_q == 3'(DATA_BITS - 1))
`ifdef PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        else
          idx_d = idx_q + 3'd1;
      end
`ifdef PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP:  if (tick) begin
        if (last_frame)              state_d = IDLE;
        else if (IDLE_GAP_BITS == 0) state_d = START;
        else begin
          state_d = GAP;
          gap_d   = 8'd0;
        end
      end
      GAP:   if (tick) begin
        if (int'(gap_q) == IDLE_GAP_BITS - 1) state_d = START;
        else                                  gap_d   = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the next state so the line changes cleanly on the edge.
    tx_d = tx_level(state_d, idx_d, data_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      data_q       <= '0;
      nbytes_q     <= '0;
      byte_count_q <= '0;
      tx_q         <= 1'b1;
      zero_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tx_q        <= tx_d;
      zero_done_q <= accept && (num_of_bytes == 8'd0);
      if (accept)
        byte_count_q <= 8'd0;
      else if (state_q == STOP && tick)
        byte_count_q <= byte_count_q + 8'd1;
      if (load) begin
        data_q   <= num;
        nbytes_q <= num_of_bytes;
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign done       = stop_done || zero_done_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_uart_burst_tx.sv
// Directed self-checking bench for uart_burst_tx (CYCLES_PER_UNIT=1, IDLE_GAP_BITS=1).
module tb_uart_burst_tx;

`ifdef PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int P16 = 16;
  localparam int FP  = P16 * (FB + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num = 8'h00;
  logic [7:0] speed = 8'h00;
  logic [7:0] num_of_bytes = 8'h00;
  logic       tx, busy, done;
  logic [7:0] byte_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_drops = 0;
  bit mon_busy = 1'b0;
  logic [7:0] pat;

  uart_burst_tx #(
    .CLK_FREQ        (100_000_000),
    .CYCLES_PER_UNIT (1),
    .IDLE_GAP_BITS   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num          (num),
    .speed        (speed),
    .num_of_bytes (num_of_bytes),
    .tx           (tx),
    .busy         (busy),
    .done         (done),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_busy && busy !== 1'b1) busy_drops++;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    step();
    reset = 1'b0;
    step();

    // 1: single frame, 0xAB, 16-cycle bit period
    num = 8'hAB; speed = 8'h10; num_of_bytes = 8'h01; start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    check("t1_start_tx_first", 32'(tx), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_cycle(16);
    check("t1_start_tx_last", 32'(tx), 32'd0);
    for (int b = 0; b < 8; b++) begin
      wait_cycle(17 + 16 * b + 8);
      check($sformatf("t1_data%0d", b), 32'(tx), 32'(pat_bit(8'hAB, b)));
    end
`ifdef PARITY_EN
    wait_cycle(145 + 8);
    check("t1_parity", 32'(tx), 32'd1);
`endif
    wait_cycle(16 * (FB - 1) + 1);
    check("t1_stop_tx", 32'(tx), 32'd1);
    wait_cycle(16 * FB - 1);
    check("t1_no_early_done", 32'(done), 32'd0);
    step();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_done_cycle", 32'(busy), 32'd1);
    step();
    check("t1_count", 32'(byte_count), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_after", 32'(done), 32'd0);

    // 2 + 4: 32-frame burst with a mid-burst reconfiguration and restart attempt
    num = 8'hAB; speed = 8'h10; num_of_bytes = 8'h20; start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    mon_busy = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (k == 2) begin
        wait_cycle(300);
        num = 8'h55; speed = 8'h01; num_of_bytes = 8'h03; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_count_kept", 32'(byte_count), 32'd1);
      end
      if (k == 4) begin
        for (int b = 0; b < 8; b++) begin
          wait_cycle(3 * FP + 1 + 16 + 16 * b + 8);
          check($sformatf("t4_f4_data%0d", b), 32'(tx), 32'(pat_bit(8'hAB, b)));
        end
      end
      wait_cycle((k - 1) * FP + 16 * FB);
      check($sformatf("t2_count_pre%0d", k), 32'(byte_count), 32'(k - 1));
      check($sformatf("t2_done_f%0d", k), 32'(done), 32'(k == 32));
      if (k == 32) begin
        check("t2_done_cycle", 32'(cyc), 32'(32 * 16 * FB + 31 * 16));
        mon_busy = 1'b0;
        start = 1'b1;
      end
      step();
      check($sformatf("t2_count_post%0d", k), 32'(byte_count), 32'(k));
    end
    check("t4_busy_continuous", 32'(busy_drops), 32'd0);
    check("t4_start_on_done_ignored", 32'(busy), 32'd0);
    check("t4_count_hold", 32'(byte_count), 32'h20);

    // 3: start one cycle after done, speed 0 -> 1-cycle bit period, 2 frames
    num = 8'hAB; speed = 8'h00; num_of_bytes = 8'h02;
    cyc = 0;
    step();
    start = 1'b0;
    check("t4_retrigger_busy", 32'(busy), 32'd1);
    check("t4_retrigger_count", 32'(byte_count), 32'd0);
    check("t3_start_tx", 32'(tx), 32'd0);
    for (int b = 0; b < 8; b++) begin
      wait_cycle(2 + b);
      check($sformatf("t3_data%0d", b), 32'(tx), 32'(pat_bit(8'hAB, b)));
    end
    wait_cycle(FB + 1);
    check("t3_gap_count", 32'(byte_count), 32'd1);
    check("t3_gap_tx", 32'(tx), 32'd1);
    wait_cycle(2 * FB + 1);
    check("t3_done", 32'(done), 32'd1);
    step();
    check("t3_count", 32'(byte_count), 32'd2);
    check("t3_idle", 32'(busy), 32'd0);

    // 5: asynchronous reset during data bit 3 of frame 5
    num = 8'hAB; speed = 8'h10; num_of_bytes = 8'h08; start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    wait_cycle(4 * FP + 1 + 16 + 48 + 5);
    check("t5_pre_count", 32'(byte_count), 32'd4);
    check("t5_pre_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_tx", 32'(tx), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_count", 32'(byte_count), 32'd0);
    step();
    reset = 1'b0;
    step();
    pat = 8'h3C;
    num = pat; speed = 8'h00; num_of_bytes = 8'h01; start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    check("t5_clean_start", 32'(tx), 32'd0);
    for (int b = 0; b < 8; b++) begin
      wait_cycle(2 + b);
      check($sformatf("t5_data%0d", b), 32'(tx), 32'(pat_bit(pat, b)));
    end
`ifdef PARITY_EN
    wait_cycle(10);
    check("t5_parity", 32'(tx), 32'd0);
`endif
    wait_cycle(FB);
    check("t5_stop", 32'(tx), 32'd1);
    check("t5_done", 32'(done), 32'd1);
    step();
    check("t5_count", 32'(byte_count), 32'd1);

    // 6: zero-length burst
    num = 8'hAB; speed = 8'h10; num_of_bytes = 8'h00; start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    check("t6_done", 32'(done), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_tx", 32'(tx), 32'd1);
    check("t6_count", 32'(byte_count), 32'd0);
    step();
    check("t6_done_once", 32'(done), 32'd0);
    wait_cycle(20);
    check("t6_busy_never", 32'(busy), 32'd0);
    check("t6_tx_idle", 32'(tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic pat_bit(input logic [7:0] v, input int b);
    return v[b];
  endfunction

endmodule
